// File: rtl/afe2256_lvds_pkg.sv
// Shared types and defaults for the AFE2256 LVDS receive path.
package afe2256_lvds_pkg;

   typedef enum logic [1:0] {
      WAIT_ALIGN = 2'd0,
      WAIT_FRAME = 2'd1,
      ASSEMBLE   = 2'd2
   } recon_state_t;

   localparam int unsigned AFE2256_NIBBLE_W         = 4;
   localparam int unsigned AFE2256_SAMPLE_BITS      = 16;
   localparam int unsigned AFE2256_SAMPLES_PER_LINE = 256;

endpackage

// File: rtl/afe2256_sample_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdata_o whenever empty_o is low.
module afe2256_sample_fifo #(
   parameter  int unsigned WIDTH = 24,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic             clkdiv,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [LW-1:0]    level_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [LW-1:0]    wr_ptr_q;
   logic [LW-1:0]    rd_ptr_q;
   logic             wr_en;
   logic             rd_en;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (level_o == LW'(DEPTH));
   assign empty_o = (level_o == '0);
   assign rd_en   = pop_i & ~empty_o & ~flush_i;
   assign wr_en   = push_i & (~full_o | rd_en) & ~flush_i;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clkdiv) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

   always_ff @(posedge clkdiv or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + LW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + LW'(1);
      end
   end

endmodule

// File: rtl/afe2256_sample_reconstructor.sv
// Assembles framed DDR nibbles into line-indexed ADC samples and queues them for the merger.
// Define AFE2256_RAMP_CHECK_EN to add the ramp_err_cnt_o test-pattern checker.
module afe2256_sample_reconstructor
   import afe2256_lvds_pkg::*;
#(
   parameter  int unsigned SAMPLE_BITS      = AFE2256_SAMPLE_BITS,
   parameter  int unsigned SAMPLES_PER_LINE = AFE2256_SAMPLES_PER_LINE,
   parameter  int unsigned FIFO_DEPTH       = 8,
   localparam int unsigned NPS   = SAMPLE_BITS / AFE2256_NIBBLE_W,
   localparam int unsigned CNT_W = $clog2(NPS),
   localparam int unsigned IDX_W = $clog2(SAMPLES_PER_LINE),
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                        clkdiv,
   input  logic                        rst_n,
   input  logic [AFE2256_NIBBLE_W-1:0] din_i,
   input  logic                        din_valid_i,
   input  logic                        frame_sync_i,
   input  logic                        bit_aligned_i,
   output logic [SAMPLE_BITS-1:0]      sample_data_o,
   output logic [IDX_W-1:0]            sample_idx_o,
   output logic                        line_start_o,
   output logic                        line_end_o,
   output logic                        sample_valid_o,
   input  logic                        sample_ready_i,
   output logic [LVL_W-1:0]            fifo_level_o,
   output logic                        frame_err_o,
`ifdef AFE2256_RAMP_CHECK_EN
   output logic [15:0]                 ramp_err_cnt_o,
`endif
   output logic                        overflow_o
);

   localparam int unsigned NW = AFE2256_NIBBLE_W;

   recon_state_t           state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [SAMPLE_BITS-1:0] sr_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   frame_err_q;
   logic                   overflow_q;

   logic [SAMPLE_BITS-1:0]       sr_d;
   logic [SAMPLE_BITS-1:0]       sr_first_d;
   logic [SAMPLE_BITS-1:0]       sample_d;
   logic                         push_d;
   logic                         pop_d;
   logic                         drop_d;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [SAMPLE_BITS+IDX_W-1:0] fifo_head;

   // Nibble lands at the slot selected by cnt_q, MSB-first.
   always_comb begin
      sr_d = sr_q;
      for (int k = 0; k < NPS; k++) begin
         if (cnt_q == CNT_W'(k)) sr_d[SAMPLE_BITS-1-NW*k -: NW] = din_i;
      end
   end

   assign sr_first_d = {din_i, sr_q[SAMPLE_BITS-NW-1:0]};
   assign sample_d   = {sr_q[SAMPLE_BITS-1:NW], din_i};
   assign push_d     = bit_aligned_i && (state_q == ASSEMBLE) && din_valid_i &&
                       !frame_sync_i && (cnt_q == CNT_W'(NPS-1));
   assign pop_d      = ~fifo_empty & sample_ready_i;
   assign drop_d     = push_d & fifo_full & ~pop_d;

   always_ff @(posedge clkdiv or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WAIT_ALIGN;
         cnt_q       <= '0;
         sr_q        <= '0;
         idx_q       <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (!bit_aligned_i) begin
            state_q    <= WAIT_ALIGN;
            cnt_q      <= '0;
            sr_q       <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (drop_d) overflow_q <= 1'b1;
            case (state_q)
               WAIT_ALIGN: state_q <= WAIT_FRAME;
               WAIT_FRAME: begin
                  if (din_valid_i && frame_sync_i) begin
                     sr_q    <= sr_first_d;
                     cnt_q   <= CNT_W'(1);
                     state_q <= ASSEMBLE;
                  end
               end
               ASSEMBLE: begin
                  if (din_valid_i) begin
                     if (frame_sync_i) begin
                        // A mid-sample sync discards the partial sample and restarts here.
                        frame_err_q <= (cnt_q != '0);
                        sr_q        <= sr_first_d;
                        cnt_q       <= CNT_W'(1);
                     end else if (cnt_q == '0) begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_FRAME;
                     end else if (push_d) begin
                        cnt_q <= '0;
                        idx_q <= (idx_q == IDX_W'(SAMPLES_PER_LINE-1)) ? '0 : idx_q + IDX_W'(1);
                     end else begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
               end
               default: state_q <= WAIT_ALIGN;
            endcase
         end
      end
   end

   afe2256_sample_fifo #(
      .WIDTH (SAMPLE_BITS + IDX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clkdiv  (clkdiv),
      .rst_n   (rst_n),
      .push_i  (push_d),
      .wdata_i ({sample_d, idx_q}),
      .pop_i   (pop_d),
      .flush_i (~bit_aligned_i),
      .rdata_o (fifo_head),
      .level_o (fifo_level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign sample_valid_o = ~fifo_empty;
   assign sample_data_o  = fifo_empty ? '0 : fifo_head[SAMPLE_BITS+IDX_W-1:IDX_W];
   assign sample_idx_o   = fifo_empty ? '0 : fifo_head[IDX_W-1:0];
   assign line_start_o   = ~fifo_empty && (fifo_head[IDX_W-1:0] == '0);
   assign line_end_o     = ~fifo_empty && (fifo_head[IDX_W-1:0] == IDX_W'(SAMPLES_PER_LINE-1));
   assign frame_err_o    = frame_err_q;
   assign overflow_o     = overflow_q;

`ifdef AFE2256_RAMP_CHECK_EN
   logic [SAMPLE_BITS-1:0] ramp_ref_q;
   logic                   ramp_have_ref_q;
   logic [15:0]            ramp_err_cnt_q;
   logic                   ramp_wr_d;
   logic                   ramp_rearm_d;

   assign ramp_wr_d    = push_d & ~drop_d;
   // Any entry into WAIT_FRAME means the next sample only seeds the reference.
   assign ramp_rearm_d = (state_q == WAIT_ALIGN) ||
                         ((state_q == ASSEMBLE) && din_valid_i && !frame_sync_i && (cnt_q == '0));

   always_ff @(posedge clkdiv or negedge rst_n) begin
      if (!rst_n) begin
         ramp_ref_q      <= '0;
         ramp_have_ref_q <= 1'b0;
         ramp_err_cnt_q  <= '0;
      end else if (!bit_aligned_i) begin
         ramp_ref_q      <= '0;
         ramp_have_ref_q <= 1'b0;
         ramp_err_cnt_q  <= '0;
      end else if (ramp_rearm_d) begin
         ramp_have_ref_q <= 1'b0;
      end else if (ramp_wr_d) begin
         ramp_ref_q      <= sample_d;
         ramp_have_ref_q <= 1'b1;
         if (ramp_have_ref_q && (sample_d != ramp_ref_q + SAMPLE_BITS'(1)) &&
             (ramp_err_cnt_q != 16'hFFFF)) begin
            ramp_err_cnt_q <= ramp_err_cnt_q + 16'd1;
         end
      end
   end

   assign ramp_err_cnt_o = ramp_err_cnt_q;
`endif

endmodule

// File: doc/afe2256_sample_reconstructor.md
Name: afe2256_sample_reconstructor

Overview:
Downstream of the per-channel AFE2256 LVDS deserializer, in the same clkdiv clock region. Assembles the aligned 4-bit DDR nibble stream into full ADC samples, framed by frame_sync, and tags each sample with its index within a readout line. Buffers samples in a small FWFT FIFO with valid/ready handshake toward the channel merger. Reports framing and overflow errors.

Parameters:
SAMPLE_BITS, 16, sample width; must be a multiple of 4 and ≥ 8; NPS = SAMPLE_BITS/4 nibbles per sample.
SAMPLES_PER_LINE, 256, samples per readout line; sample_idx wraps after SAMPLES_PER_LINE-1.
FIFO_DEPTH, 8, output FIFO entries; power of two, ≥ 2.

Ports:
clkdiv  in  1  DCLK/4 regional clock.
rst_n  in  1  reset, asynchronous, active-low.
din  in  4  deserialized nibble, MSB-first within a sample.
din_valid  in  1  din qualifier (deserializer in CAPTURE).
frame_sync  in  1  marks the first nibble of a sample; same cycle as that nibble.
bit_aligned  in  1  deserializer alignment status.
sample_data  out  SAMPLE_BITS  FIFO head sample.
sample_idx  out  $clog2(SAMPLES_PER_LINE)  index of head sample in line.
line_start  out  1  head sample has sample_idx==0.
line_end  out  1  head sample has sample_idx==SAMPLES_PER_LINE-1.
sample_valid  out  1  FIFO not empty.
sample_ready  in  1  consumer accepts head when sample_valid.
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
frame_err  out  1  one-cycle pulse per framing error.
overflow  out  1  sticky: a completed sample was dropped.

Behaviour:
- Reset: state WAIT_ALIGN, nibble_cnt=0, shift reg=0, idx=0, FIFO empty. Outputs: sample_data=0, sample_idx=0, line_start=0, line_end=0, sample_valid=0, fifo_level=0, frame_err=0, overflow=0.
- FSM (clkdiv):
  WAIT_ALIGN: leave for WAIT_FRAME when bit_aligned=1.
  WAIT_FRAME: on din_valid & frame_sync, load din into bits [SB-1:SB-4], nibble_cnt=1, go to ASSEMBLE. Nibbles without frame_sync are ignored.
  ASSEMBLE: each din_valid cycle shifts in din (MSB-first) and increments nibble_cnt. din_valid=0 holds state (a stall, not an error).
- Sample completion: the valid nibble with nibble_cnt==NPS-1 completes the sample. Push {sample, idx} into the FIFO, nibble_cnt=0, idx = (idx==SAMPLES_PER_LINE-1) ? 0 : idx+1.
- Boundary checks in ASSEMBLE:
  - frame_sync with nibble_cnt≠0: frame_err pulse, partial sample discarded, current nibble restarts a sample (nibble_cnt=1), idx unchanged.
  - Valid nibble with nibble_cnt==0 and no frame_sync: frame_err pulse, go to WAIT_FRAME, nibble discarded.
  - frame_sync with nibble_cnt==0 is the normal case.
- bit_aligned falls in any state: go to WAIT_ALIGN the next cycle, discard the partial sample, reset idx to 0, flush the FIFO, clear overflow. The FIFO is not flushed on frame_err.
- Latency: last nibble at cycle N → sample_valid/sample_data at N+1 (registered write, FWFT head).
- Handshake: pop when sample_valid & sample_ready. Head data stays stable while sample_valid & !sample_ready.
- Full: a push with the FIFO full and no pop in the same cycle drops the new sample and sets overflow. A push with the FIFO full and a simultaneous pop succeeds, level unchanged. A push with the FIFO empty and sample_ready=1 does not bypass; the sample appears next cycle.
- fifo_level tracks push-pop each cycle, range 0..FIFO_DEPTH.

Optional Feature:
Macro AFE2256_RAMP_CHECK_EN.
- With the macro: add output ramp_err_cnt [15:0]. Every pushed sample is compared against previous pushed sample+1 (mod 2^SAMPLE_BITS); a mismatch increments the counter, saturating at 16'hFFFF. The first sample after WAIT_FRAME entry sets the reference and is not compared. Counter clears on reset and on bit_aligned fall.
- Without the macro: the port and the logic are absent.

Decomposition:
- afe2256_lvds_pkg gets: recon_state_t enum (WAIT_ALIGN, WAIT_FRAME, ASSEMBLE), AFE2256_NIBBLE_W=4, AFE2256_SAMPLE_BITS=16, AFE2256_SAMPLES_PER_LINE=256.
- Sub-module afe2256_sample_fifo: synchronous FWFT FIFO with data width SAMPLE_BITS+idx width, push/pop/flush, level, full/empty.

Test Plan:
- Aligned, frame_sync every 4th valid nibble, nibbles 1,2,3,4 → sample_data=16'h1234, sample_idx=0, line_start=1, sample_valid one cycle after the 4th nibble.
- 256 consecutive samples with sample_ready=1 → idx 0..255 then 0; line_end=1 only on idx 255; no frame_err.
- sample_ready=0, 9 samples, FIFO_DEPTH=8 → fifo_level=8, overflow=1, the 9th is dropped; drain returns the first 8 in order.
- frame_sync after 2 nibbles (A,B) then C,D,E,F → frame_err pulse, next sample=16'hCDEF. Separately, a missing frame_sync at a boundary → frame_err pulse and no push until the next frame_sync.
- bit_aligned deasserted mid-sample with 3 entries queued → next cycle fifo_level=0, sample_valid=0, overflow=0; after realign the next sample has idx=0.
- With AFE2256_RAMP_CHECK_EN: ramp 0x0000..0x00FF with one corrupted value → ramp_err_cnt=2 (the break and the recovery).
